pll_lock_supervisor: RTL
========================

PLL_LOCK_SUPERVISOR -- requirements
Module: pll_lock_supervisor

Interface
REQ-001 SHALL have parameter RST_CYCLES, default 16: cycles pll_reset is held high per PLL reset pulse.
REQ-002 SHALL have parameter LOCK_TIMEOUT, default 50000: WAIT_LOCK cycles before retry (1 ms at 50 MHz).
REQ-003 SHALL have parameter STABLE_CYCLES, default 1024: consecutive synchronized-lock-high cycles required before release.
REQ-004 SHALL have port clk, input, 1 bit: free-running 50 MHz board clock (PLL reference, never the PLL output).
REQ-005 SHALL have port reset, input, 1 bit: synchronous, active-high.
REQ-006 SHALL have port pll_lock, input, 1 bit: PLL LOCK, asynchronous to clk.
REQ-007 SHALL have port force_relock, input, 1 bit: single-cycle request to restart the PLL.
REQ-008 SHALL have port pll_reset, output, 1 bit: drives the PLL RESET pin, active-high.
REQ-009 SHALL have port sys_reset, output, 1 bit: active-high reset for downstream logic on the 160 MHz clock.
REQ-010 SHALL have port locked, output, 1 bit: high only in RUN.
REQ-011 SHALL have port relock_count, output, 8 bits: lock losses seen in RUN, saturating.
REQ-012 SHALL have port timeout_count, output, 8 bits: WAIT_LOCK timeouts, saturating.

Function
REQ-013 SHALL pass pll_lock through a 2-flop synchronizer to form lock_s; all decisions use lock_s only.
REQ-014 SHALL implement four states: PLL_RST, WAIT_LOCK, STABLE, RUN, with one shared down/up counter.
REQ-015 PLL_RST SHALL hold pll_reset=1 for exactly RST_CYCLES cycles, then enter WAIT_LOCK with counter cleared.
REQ-016 WAIT_LOCK SHALL enter STABLE, counter cleared, on the first cycle lock_s=1.
REQ-017 WAIT_LOCK SHALL enter PLL_RST and increment timeout_count when lock_s stays 0 for LOCK_TIMEOUT cycles.
REQ-018 STABLE SHALL enter RUN after STABLE_CYCLES consecutive cycles with lock_s=1; any lock_s=0 returns it to WAIT_LOCK with counter cleared.
REQ-019 RUN SHALL enter PLL_RST and increment relock_count on a qualified lock loss (REQ-028/029).
REQ-020 force_relock=1 in WAIT_LOCK, STABLE or RUN SHALL enter PLL_RST next cycle without incrementing either count; it SHALL be ignored in PLL_RST.
REQ-021 Simultaneous force_relock and lock loss in RUN SHALL enter PLL_RST once, with relock_count unchanged.
REQ-022 sys_reset SHALL be 0 exactly when state is RUN and 1 in every other state; locked SHALL equal ~sys_reset; both are registered.
REQ-023 Counters SHALL saturate at 255 and never wrap.
REQ-024 pll_reset SHALL be registered and glitch-free.

Reset
REQ-025 reset=1 SHALL force state PLL_RST with counter 0, pll_reset=1, sys_reset=1, locked=0, relock_count=0, timeout_count=0, and synchronizer flops 0.
REQ-026 Assertion of reset mid-operation SHALL take effect the next clock edge from any state, with no partial counter carry-over.
REQ-027 The RST_CYCLES pulse SHALL begin on the first cycle after reset deasserts.

Configuration
REQ-028 With LOCK_GLITCH_FILTER_EN defined, a lock loss in RUN SHALL qualify only after lock_s=0 for 4 consecutive cycles; shorter dropouts SHALL be ignored and SHALL not change the count.
REQ-029 Without LOCK_GLITCH_FILTER_EN, a single lock_s=0 cycle in RUN SHALL qualify; no filter logic SHALL be synthesized.

Structure
REQ-030 Package pll_sup_pkg SHALL hold the state enum, the counter width (derived from the maximum of LOCK_TIMEOUT and STABLE_CYCLES), and the saturating-count width of 8.
REQ-031 Sub-module lock_sync SHALL implement the 2-flop synchronizer; it SHALL carry no reset-free logic beyond those flops.

Verification (bench parameters RST_CYCLES=4, LOCK_TIMEOUT=20, STABLE_CYCLES=8)
REQ-032 Release reset with pll_lock=1 constant -> pll_reset high 4 cycles; sys_reset falls 2 + 8 (+ state-entry) cycles later; locked=1; both counts 0.
REQ-033 pll_lock held 0 -> pll_reset repulses every 4+20 cycles; timeout_count reaches 3 after three retries and saturates at 255.
REQ-034 In STABLE, drop pll_lock for 1 cycle at count 5 -> STABLE restarts; RUN is reached 8 full high cycles after recovery.
REQ-035 In RUN, with LOCK_GLITCH_FILTER_EN defined: a 2-cycle drop -> stays RUN, relock_count=0; a 4-cycle drop -> PLL_RST, relock_count=1. Without the macro, a 1-cycle drop -> PLL_RST.
REQ-036 In RUN, force_relock pulse coincident with a lock drop -> one PLL_RST pulse of 4 cycles, relock_count unchanged, sys_reset=1 within 1 cycle.

Source files
------------

// File: rtl/pll_sup_pkg.sv
// Shared state type and sizing helpers for the PLL lock supervisor.
package pll_sup_pkg;

  typedef enum logic [1:0] {
    S_PLL_RST   = 2'd0,
    S_WAIT_LOCK = 2'd1,
    S_STABLE    = 2'd2,
    S_RUN       = 2'd3
  } state_t;

  localparam int SAT_W = 8;
  localparam logic [SAT_W-1:0] SAT_MAX = '1;

  // The shared counter must reach the largest terminal count of any state;
  // a floor of 4 leaves room for the RUN-state dropout filter.
  function automatic int cnt_width(input int lock_timeout, input int stable_cycles,
                                   input int rst_cycles);
    int m;
    m = (lock_timeout > stable_cycles) ? lock_timeout : stable_cycles;
    if (rst_cycles > m) m = rst_cycles;
    if (m < 4) m = 4;
    return $clog2(m + 1);
  endfunction

  function automatic logic [SAT_W-1:0] sat_inc(input logic [SAT_W-1:0] v);
    return (v == SAT_MAX) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/lock_sync.sv
// Two-flop synchronizer bringing the asynchronous PLL lock into the clk domain.
module lock_sync (
  input  logic clk,
  input  logic reset,
  input  logic i_async,
  output logic o_sync
);

  logic [1:0] r_sync;

  always_ff @(posedge clk) begin
    if (reset) r_sync <= '0;
    else       r_sync <= {r_sync[0], i_async};
  end

  assign o_sync = r_sync[1];

endmodule

// File: rtl/pll_lock_supervisor.sv
// PLL reset sequencer: pulses the PLL reset, waits for a stable lock, then
// releases downstream reset. Define LOCK_GLITCH_FILTER_EN to ignore <4-cycle dropouts in RUN.
module pll_lock_supervisor
  import pll_sup_pkg::*;
#(
  parameter int RST_CYCLES    = 16,
  parameter int LOCK_TIMEOUT  = 50000,
  parameter int STABLE_CYCLES = 1024
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pll_lock,
  input  logic             force_relock,
  output logic             pll_reset,
  output logic             sys_reset,
  output logic             locked,
  output logic [SAT_W-1:0] relock_count,
  output logic [SAT_W-1:0] timeout_count,
  output state_t           dbg_state
);

  localparam int CNT_W = cnt_width(LOCK_TIMEOUT, STABLE_CYCLES, RST_CYCLES);
  localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
`ifdef LOCK_GLITCH_FILTER_EN
  localparam logic [CNT_W-1:0] LOSS_LAST   = CNT_W'(3);
`endif

  logic             w_lock_s;
  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_pll_reset;
  logic             r_sys_reset;
  logic             r_locked;
  logic [SAT_W-1:0] r_relock_cnt;
  logic [SAT_W-1:0] r_timeout_cnt;

  lock_sync u_lock_sync (
    .clk     (clk),
    .reset   (reset),
    .i_async (pll_lock),
    .o_sync  (w_lock_s)
  );

  // Outputs are registered alongside the state so they always track it exactly.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= S_PLL_RST;
      r_cnt         <= '0;
      r_pll_reset   <= 1'b1;
      r_sys_reset   <= 1'b1;
      r_locked      <= 1'b0;
      r_relock_cnt  <= '0;
      r_timeout_cnt <= '0;
    end else begin
      case (r_state)
        S_PLL_RST: begin
          if (r_cnt == RST_LAST) begin
            r_state     <= S_WAIT_LOCK;
            r_cnt       <= '0;
            r_pll_reset <= 1'b0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_WAIT_LOCK: begin
          if (force_relock || (!w_lock_s && r_cnt == TIMEOUT_LAST)) begin
            r_state     <= S_PLL_RST;
            r_cnt       <= '0;
            r_pll_reset <= 1'b1;
            if (!force_relock) r_timeout_cnt <= sat_inc(r_timeout_cnt);
          end else if (w_lock_s) begin
            r_state <= S_STABLE;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_STABLE: begin
          if (force_relock) begin
            r_state     <= S_PLL_RST;
            r_cnt       <= '0;
            r_pll_reset <= 1'b1;
          end else if (!w_lock_s) begin
            r_state <= S_WAIT_LOCK;
            r_cnt   <= '0;
          end else if (r_cnt == STABLE_LAST) begin
            r_state     <= S_RUN;
            r_cnt       <= '0;
            r_sys_reset <= 1'b0;
            r_locked    <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_RUN: begin
          // In RUN the shared counter tracks consecutive low lock_s cycles.
          if (force_relock) begin
            r_state     <= S_PLL_RST;
            r_cnt       <= '0;
            r_pll_reset <= 1'b1;
            r_sys_reset <= 1'b1;
            r_locked    <= 1'b0;
`ifdef LOCK_GLITCH_FILTER_EN
          end else if (!w_lock_s && r_cnt == LOSS_LAST) begin
`else
          end else if (!w_lock_s) begin
`endif
            r_state      <= S_PLL_RST;
            r_cnt        <= '0;
            r_pll_reset  <= 1'b1;
            r_sys_reset  <= 1'b1;
            r_locked     <= 1'b0;
            r_relock_cnt <= sat_inc(r_relock_cnt);
`ifdef LOCK_GLITCH_FILTER_EN
          end else if (!w_lock_s) begin
            r_cnt <= r_cnt + 1'b1;
`endif
          end else begin
            r_cnt <= '0;
          end
        end
        default: begin
          r_state     <= S_PLL_RST;
          r_cnt       <= '0;
          r_pll_reset <= 1'b1;
          r_sys_reset <= 1'b1;
          r_locked    <= 1'b0;
        end
      endcase
    end
  end

  assign pll_reset     = r_pll_reset;
  assign sys_reset     = r_sys_reset;
  assign locked        = r_locked;
  assign relock_count  = r_relock_cnt;
  assign timeout_count = r_timeout_cnt;
  assign dbg_state     = r_state;

endmodule
